// File: rtl/flash_arb_pkg.sv
// Shared constants for the quad-SPI flash bus arbiter: FSM encodings,
// master indices and the pad values driven whenever nobody owns the flash.
package flash_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DBG = 1'b1;

  localparam logic       IDLE_NCE  = 1'b1;
  localparam logic       IDLE_SCLK = 1'b0;
  localparam logic       IDLE_OE   = 1'b0;
  localparam logic       IDLE_QPI  = 1'b0;
  localparam logic [3:0] IDLE_SOUT = 4'h0;

  function automatic logic [1:0] mst_onehot(input logic idx);
    return (idx == MST_DBG) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/flash_bus_arb.sv
// Two-master arbiter for the configuration flash: round-robin ownership,
// a forced nCE-high guard gap between owners, and an advisory yield hint.
module flash_bus_arb
  import flash_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int MAX_HOLD     = 4096,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] m_req,
  output logic [1:0] m_gnt,
  output logic [1:0] m_preempt,
  input  logic [1:0] m_nce,
  input  logic [1:0] m_sclk,
  input  logic [7:0] m_sout,
  input  logic [1:0] m_oe,
  input  logic [1:0] m_bus_qpi,
  output logic [3:0] m_sin,
  output logic       flash_nce,
  output logic       flash_sclk,
  output logic [3:0] flash_sout,
  output logic       flash_oe,
  output logic       flash_bus_qpi,
  output logic       flash_selected,
  input  logic [3:0] flash_sin,
  output logic       err_abort
);

  localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0]    GUARD_LD = GW'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic             HOLD_EN  = (MAX_HOLD != 0);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [GW-1:0]    guard_cnt_q, guard_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             err_q, err_d;

  logic own, req_own, nce_own, req_other;

  assign own       = (state_q == ST_OWN);
  assign req_own   = m_req[owner_q];
  assign nce_own   = m_nce[owner_q];
  assign req_other = m_req[~owner_q];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    guard_cnt_d  = guard_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    gnt_d        = gnt_q;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|m_req) begin
          // On contention the master that did not own last goes next.
          if (&m_req) owner_d = ~last_owner_q;
          else        owner_d = m_req[MST_DBG] ? MST_DBG : MST_CPU;
          gnt_d      = mst_onehot(owner_d);
          hold_cnt_d = '0;
          state_d    = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!req_own) begin
          // Dropping req with nCE still low truncates a transfer; the pads
          // go idle next cycle either way, but software gets told.
          state_d      = ST_GUARD;
          gnt_d        = 2'b00;
          last_owner_d = owner_q;
          guard_cnt_d  = GUARD_LD;
          err_d        = ~nce_own;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q <= GW'(1)) state_d = ST_IDLE;
        else                       guard_cnt_d = guard_cnt_q - 1'b1;
      end
      default: begin
        state_d     = ST_GUARD;
        guard_cnt_d = GUARD_LD;
        gnt_d       = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_GUARD;
      owner_q      <= MST_CPU;
      last_owner_q <= MST_DBG;
      guard_cnt_q  <= GUARD_LD;
      hold_cnt_q   <= '0;
      gnt_q        <= 2'b00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      guard_cnt_q  <= guard_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      gnt_q        <= gnt_d;
      err_q        <= err_d;
    end
  end

  // Pads follow the owner only while in OWN, so reset and GUARD force
  // nCE high with no dependence on the requesting masters.
  always_comb begin
    flash_nce      = IDLE_NCE;
    flash_sclk     = IDLE_SCLK;
    flash_sout     = IDLE_SOUT;
    flash_oe       = IDLE_OE;
    flash_bus_qpi  = IDLE_QPI;
    if (own) begin
      flash_nce     = m_nce[owner_q];
      flash_sclk    = m_sclk[owner_q];
      flash_sout    = owner_q ? m_sout[7:4] : m_sout[3:0];
      flash_oe      = m_oe[owner_q];
      flash_bus_qpi = m_bus_qpi[owner_q];
    end
  end

  assign flash_selected = own;
  assign m_sin          = flash_sin;
  assign m_gnt          = gnt_q;
  assign err_abort      = err_q;
  assign m_preempt      = (own && HOLD_EN && (hold_cnt_q >= HOLD_LIM) && req_other)
                          ? mst_onehot(owner_q) : 2'b00;

endmodule

// File: tb/tb_flash_bus_arb.sv
// Scenario bench for flash_bus_arb: each task drives a scenario, queues the
// expected output snapshot and compares it against the DUT when sampled.
module tb_flash_bus_arb;

  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] m_req, m_gnt, m_preempt, m_nce, m_sclk, m_oe, m_bus_qpi;
  logic [7:0] m_sout;
  logic [3:0] m_sin, flash_sout, flash_sin;
  logic       flash_nce, flash_sclk, flash_oe, flash_bus_qpi, flash_selected, err_abort;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      n;
    logic [17:0] v;
  } exp_t;
  exp_t sb[$];

  flash_bus_arb #(.GUARD_CYCLES(G), .MAX_HOLD(8), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_gnt(m_gnt), .m_preempt(m_preempt),
    .m_nce(m_nce), .m_sclk(m_sclk), .m_sout(m_sout), .m_oe(m_oe),
    .m_bus_qpi(m_bus_qpi), .m_sin(m_sin), .flash_nce(flash_nce),
    .flash_sclk(flash_sclk), .flash_sout(flash_sout), .flash_oe(flash_oe),
    .flash_bus_qpi(flash_bus_qpi), .flash_selected(flash_selected),
    .flash_sin(flash_sin), .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  // {gnt, preempt, err, selected, nce, sclk, oe, qpi, sout, sin}
  function automatic logic [17:0] mk(input logic [1:0] g, input logic [1:0] p,
                                     input logic e, input logic s, input logic n,
                                     input logic c, input logic o, input logic q,
                                     input logic [3:0] so, input logic [3:0] si);
    return {g, p, e, s, n, c, o, q, so, si};
  endfunction

  function automatic logic [17:0] snap();
    return {m_gnt, m_preempt, err_abort, flash_selected, flash_nce, flash_sclk,
            flash_oe, flash_bus_qpi, flash_sout, m_sin};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_req = 2'b00; m_nce = 2'b11; m_sclk = 2'b00; m_sout = 8'h00;
    m_oe = 2'b00; m_bus_qpi = 2'b00; flash_sin = 4'h3;
  endtask

  // Leaves the DUT in the first IDLE cycle after reset (last_owner = 1).
  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
    repeat (G) cyc();
  endtask

  task automatic test_reset();
    exp_t e; logic [17:0] got;
    idle_inputs();
    m_req = 2'b01;
    rstn = 1'b0;
    cyc();
    sb.push_back('{"reset_idle", mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0, 4'h3)});
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    cyc();
    rstn = 1'b1;
    // Grant is visible after the (G+1)th edge following reset release.
    for (int k = 1; k <= G + 1; k++) begin
      cyc();
      if (k <= G) sb.push_back('{$sformatf("reset_guard_%0d", k), mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0, 4'h3)});
      else        sb.push_back('{"reset_first_gnt", mk(2'b01, 2'b00, 0, 1, 1, 0, 0, 0, 4'h0, 4'h3)});
      got = snap(); e = sb.pop_front(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    end
    m_nce = 2'b10; m_sclk = 2'b01;
    sb.push_back('{"reset_nce_follow", mk(2'b01, 2'b00, 0, 1, 0, 1, 0, 0, 4'h0, 4'h3)});
    #1;
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    m_nce = 2'b11; m_sclk = 2'b00; m_req = 2'b00;
    sb.push_back('{"reset_clean_release", mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0, 4'h3)});
    cyc();
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
  endtask

  task automatic test_round_robin();
    exp_t e; logic [17:0] got;
    do_reset();
    m_req = 2'b11;
    sb.push_back('{"rr_first_m0", mk(2'b01, 2'b00, 0, 1, 1, 0, 0, 0, 4'h0, 4'h3)});
    cyc();
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    m_req = 2'b10;
    for (int k = 0; k <= G; k++) begin
      sb.push_back('{$sformatf("rr_gap_%0d", k), mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0, 4'h3)});
      cyc();
      got = snap(); e = sb.pop_front(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    end
    sb.push_back('{"rr_then_m1", mk(2'b10, 2'b00, 0, 1, 1, 0, 0, 0, 4'h0, 4'h3)});
    cyc();
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    m_req = 2'b11;
    repeat (2) begin
      sb.push_back('{"rr_m1_keeps", mk(2'b10, 2'b00, 0, 1, 1, 0, 0, 0, 4'h0, 4'h3)});
      cyc();
      got = snap(); e = sb.pop_front(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    end
    m_req = 2'b01;
    repeat (G + 1) begin
      sb.push_back('{"rr_gap2", mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0, 4'h3)});
      cyc();
      got = snap(); e = sb.pop_front(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    end
    sb.push_back('{"rr_back_to_m0", mk(2'b01, 2'b00, 0, 1, 1, 0, 0, 0, 4'h0, 4'h3)});
    cyc();
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    m_req = 2'b00;
    cyc();
  endtask

  task automatic test_mux();
    exp_t e; logic [17:0] got;
    do_reset();
    m_req = 2'b10; m_sout = 8'hA5; m_oe = 2'b10; m_bus_qpi = 2'b10;
    m_nce = 2'b01; m_sclk = 2'b10;
    sb.push_back('{"mux_owner1", mk(2'b10, 2'b00, 0, 1, 0, 1, 1, 1, 4'hA, 4'h3)});
    cyc();
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    m_nce = 2'b10; m_sclk = 2'b01; m_sout = 8'h0F; m_oe = 2'b01; m_bus_qpi = 2'b01;
    flash_sin = 4'hC;
    sb.push_back('{"mux_ignore_m0", mk(2'b10, 2'b00, 0, 1, 1, 0, 0, 0, 4'h0, 4'hC)});
    #1;
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    m_req = 2'b00;
    sb.push_back('{"mux_release_idle", mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0, 4'hC)});
    cyc();
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    idle_inputs();
  endtask

  task automatic test_preempt();
    exp_t e; logic [17:0] got;
    do_reset();
    m_req = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      sb.push_back('{$sformatf("pre_m0_cyc%0d", k),
                     mk(2'b01, (k >= 9) ? 2'b01 : 2'b00, 0, 1, 1, 0, 0, 0, 4'h0, 4'h3)});
      got = snap(); e = sb.pop_front(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
      if (k == 3) m_req = 2'b11;
    end
    m_req = 2'b10;
    sb.push_back('{"pre_held_til_rel", mk(2'b01, 2'b01, 0, 1, 1, 0, 0, 0, 4'h0, 4'h3)});
    #1;
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    sb.push_back('{"pre_clear_on_rel", mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0, 4'h3)});
    cyc();
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    repeat (G) cyc();
    m_req = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      sb.push_back('{$sformatf("pre_m1_cyc%0d", k),
                     mk(2'b10, (k >= 9) ? 2'b10 : 2'b00, 0, 1, 1, 0, 0, 0, 4'h0, 4'h3)});
      got = snap(); e = sb.pop_front(); total++;
      if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    end
    m_req = 2'b10;
    sb.push_back('{"pre_other_drops", mk(2'b10, 2'b00, 0, 1, 1, 0, 0, 0, 4'h0, 4'h3)});
    #1;
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    m_req = 2'b00;
    cyc();
  endtask

  task automatic test_violation();
    exp_t e; logic [17:0] got;
    do_reset();
    m_req = 2'b01;
    cyc();
    m_nce = 2'b10;
    sb.push_back('{"viol_nce_low", mk(2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 4'h0, 4'h3)});
    #1;
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    m_req = 2'b00;
    sb.push_back('{"viol_err_pulse", mk(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 4'h0, 4'h3)});
    cyc();
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    sb.push_back('{"viol_err_single", mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0, 4'h3)});
    cyc();
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    m_nce = 2'b11;
  endtask

  task automatic test_async_reset();
    exp_t e; logic [17:0] got;
    do_reset();
    m_req = 2'b01;
    cyc();
    m_nce = 2'b10; m_sclk = 2'b01;
    sb.push_back('{"arst_pre_xfer", mk(2'b01, 2'b00, 0, 1, 0, 1, 0, 0, 4'h0, 4'h3)});
    #1;
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    #1;
    rstn = 1'b0;
    sb.push_back('{"arst_immediate", mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0, 4'h3)});
    #1;
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    m_sclk = 2'b00; #1; m_sclk = 2'b01;
    sb.push_back('{"arst_sclk_blocked", mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0, 4'h3)});
    #1;
    got = snap(); e = sb.pop_front(); total++;
    if (got !== e.v) begin bad++; $display("FAIL %s: got %b want %b", e.n, got, e.v); end
    idle_inputs();
    cyc();
    rstn = 1'b1;
    cyc();
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    test_reset();
    test_round_robin();
    test_mux();
    test_preempt();
    test_violation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
